// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX byte port between NUM_REQ requesters.
// Arbitration is round-robin, and a granted requester keeps the port for a whole packet.
// Latency: grant 1 cycle after req is sampled; the byte strobe follows 1 cycle after grant if the transmitter is free.
// Backpressure: busy or block holds the owner in WAIT_TX indefinitely. Each accepted byte is acked with a one-cycle req_ack pulse.
// Ports:
//   clk, rst (async, active-high)
//   req / req_data / req_last / req_ack : requester handshake
//   busy / block / new_data_tx / data_tx : transmitter side
//   grant_valid / grant_id : current owner
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  input  logic                 busy,
  input  logic                 block,
  output logic                 new_data_tx,
  output logic [7:0]           data_tx,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_TX = 2'd1;
  localparam logic [1:0] SETTLE  = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0]         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [7:0]         burst_cnt;
  logic [7:0]         cnt_inc;

  logic               pick_found;
  logic [ID_W-1:0]    pick_id;

  logic               own_req;
  logic               own_last;
  logic [7:0]         own_data;
  logic [NUM_REQ-1:0] own_onehot;

  // Round-robin search starting at rr_ptr. Both loops are constant-bounded,
  // so every req index is a constant after unrolling.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int s = 0; s < NUM_REQ; s++) begin
      if (rr_ptr == ID_W'(s)) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!pick_found && req[(s + k) % NUM_REQ]) begin
            pick_found = 1'b1;
            pick_id    = ID_W'((s + k) % NUM_REQ);
          end
        end
      end
    end
  end

  // Select the owner's request, last flag and byte.
  always_comb begin
    own_req    = 1'b0;
    own_last   = 1'b0;
    own_data   = 8'h00;
    own_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        own_req       = req[i];
        own_last      = req_last[i];
        own_data      = req_data[8*i +: 8];
        own_onehot[i] = 1'b1;
      end
    end
  end

  assign cnt_inc = burst_cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      burst_cnt   <= 8'h00;
      new_data_tx <= 1'b0;
      data_tx     <= 8'h00;
      req_ack     <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      // Strobe and ack are single-cycle pulses. data_tx is zero whenever there is no strobe.
      new_data_tx <= 1'b0;
      data_tx     <= 8'h00;
      req_ack     <= '0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id    <= pick_id;
            grant_valid <= 1'b1;
            burst_cnt   <= 8'h00;
            state       <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (!own_req) begin
            // The owner withdrew: release without sending anything.
            grant_valid <= 1'b0;
            state       <= RELEASE;
          end else if (!busy && !block) begin
            new_data_tx <= 1'b1;
            data_tx     <= own_data;
            req_ack     <= own_onehot;
            burst_cnt   <= cnt_inc;
            if (own_last || (cnt_inc == 8'(MAX_BURST))) begin
              grant_valid <= 1'b0;
              state       <= RELEASE;
            end else begin
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          // Wait one cycle so the transmitter can raise busy for the byte just sent.
          state <= WAIT_TX;
        end
        RELEASE: begin
          // The finishing requester gets the lowest priority in the next round.
          if (grant_id == ID_W'(NUM_REQ - 1)) rr_ptr <= '0;
          else                                rr_ptr <= grant_id + ID_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=4).
// Requesters are modelled as byte queues that advance on req_ack.
// Every transmitted byte is logged with its owner and cycle, then compared with hand-computed tables.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ack;
  logic        busy = 1'b0;
  logic        block = 1'b0;
  logic        new_data_tx;
  logic [7:0]  data_tx;
  logic        grant_valid;
  logic [1:0]  grant_id;

  uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .busy(busy), .block(block), .new_data_tx(new_data_tx),
    .data_tx(data_tx), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [8:0] mem [4][16];
  int rd [4];
  int nq [4];

  int         log_id  [128];
  logic [7:0] log_dat [128];
  int         log_cyc [128];
  int         log_n = 0;
  int         g_log [64];
  int         g_n = 0;
  logic       prev_nd = 1'b0;
  logic       prev_gv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic present(input int i);
    if (rd[i] < nq[i]) begin
      req[i]             = 1'b1;
      req_last[i]        = mem[i][rd[i]][8];
      req_data[8*i +: 8] = mem[i][rd[i]][7:0];
      rd[i]++;
    end else begin
      req[i]             = 1'b0;
      req_last[i]        = 1'b0;
      req_data[8*i +: 8] = 8'h00;
    end
  endtask

  task automatic put(input int i, input logic [7:0] d, input logic l);
    mem[i][nq[i]] = {l, d};
    nq[i]++;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 4; i++) begin
      rd[i] = 0;
      nq[i] = 0;
    end
    req = '0;
    req_last = '0;
    req_data = '0;
  endtask

  // Advance one cycle, check the output invariants, log strobes and grants,
  // then let each acked requester present its next byte.
  task automatic tick();
    int id;
    @(negedge clk);
    cyc++;
    chk("ack_vs_strobe", 32'(req_ack != 4'b0000), 32'(new_data_tx));
    chk("ack_onehot", 32'($countones(req_ack) <= 1), 32'd1);
    chk("strobe_gap", 32'(prev_nd && new_data_tx), 32'd0);
    if (!new_data_tx) chk("data_idle", 32'(data_tx), 32'd0);
    if (new_data_tx && log_n < 128) begin
      id = 0;
      for (int i = 0; i < 4; i++) if (req_ack[i]) id = i;
      log_id[log_n]  = id;
      log_dat[log_n] = data_tx;
      log_cyc[log_n] = cyc;
      log_n++;
    end
    if (grant_valid && !prev_gv && g_n < 64) begin
      g_log[g_n] = int'(grant_id);
      g_n++;
    end
    prev_nd = new_data_tx;
    prev_gv = grant_valid;
    for (int i = 0; i < 4; i++) if (req_ack[i]) present(i);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_log(input int target, input int budget);
    int k;
    k = 0;
    while (log_n < target && k < budget) begin
      tick();
      k++;
    end
    chk("wait_log", 32'(log_n), 32'(target));
  endtask

  task automatic exp_log(input string tag, input int k, input int id, input logic [7:0] d);
    chk({tag, "_id"}, 32'(log_id[k]), 32'(id));
    chk({tag, "_dat"}, 32'(log_dat[k]), 32'(d));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_new_data_tx"}, 32'(new_data_tx), 32'd0);
    chk({tag, "_data_tx"}, 32'(data_tx), 32'd0);
    chk({tag, "_req_ack"}, 32'(req_ack), 32'd0);
    chk({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int g0;
    clear_reqs();
    rst = 1'b1;
    idle(2);
    chk_zero_outputs("rst");
    rst = 1'b0;

    // Single requester, one last byte.
    put(0, 8'hA5, 1'b1);
    present(0);
    tick();
    chk("t1_grant_valid", 32'(grant_valid), 32'd1);
    chk("t1_grant_id", 32'(grant_id), 32'd0);
    chk("t1_no_strobe_yet", 32'(new_data_tx), 32'd0);
    tick();
    chk("t1_strobe", 32'(new_data_tx), 32'd1);
    chk("t1_data", 32'(data_tx), 32'hA5);
    chk("t1_ack", 32'(req_ack), 32'b0001);
    tick();
    chk("t1_grant_released", 32'(grant_valid), 32'd0);
    chk("t1_strobe_cleared", 32'(new_data_tx), 32'd0);

    // Four-way contention from rr pointer 0, then requesters 0 and 3.
    clear_reqs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b = log_n;
    for (int i = 0; i < 4; i++) begin
      put(i, 8'(8'h10 + i), 1'b1);
      present(i);
    end
    wait_log(b + 4, 40);
    for (int i = 0; i < 4; i++) exp_log("t2_order", b + i, i, 8'(8'h10 + i));
    idle(3);
    b = log_n;
    put(0, 8'h20, 1'b1);
    put(3, 8'h23, 1'b1);
    present(0);
    present(3);
    wait_log(b + 2, 30);
    exp_log("t2_pair0", b, 0, 8'h20);
    exp_log("t2_pair1", b + 1, 3, 8'h23);

    // Burst by requester 2 while requester 1 waits.
    idle(3);
    clear_reqs();
    b = log_n;
    put(2, 8'h11, 1'b0);
    put(2, 8'h22, 1'b0);
    put(2, 8'h33, 1'b1);
    put(1, 8'h44, 1'b1);
    present(2);
    tick();
    chk("t3_grant_id", 32'(grant_id), 32'd2);
    present(1);
    wait_log(b + 4, 40);
    exp_log("t3_b0", b, 2, 8'h11);
    exp_log("t3_b1", b + 1, 2, 8'h22);
    exp_log("t3_b2", b + 2, 2, 8'h33);
    exp_log("t3_b3", b + 3, 1, 8'h44);
    chk("t3_spacing1", 32'(log_cyc[b + 1] - log_cyc[b]), 32'd2);
    chk("t3_spacing2", 32'(log_cyc[b + 2] - log_cyc[b + 1]), 32'd2);

    // busy asserted after the first byte of a burst.
    idle(3);
    clear_reqs();
    b = log_n;
    put(0, 8'h51, 1'b0);
    put(0, 8'h52, 1'b1);
    present(0);
    wait_log(b + 1, 20);
    busy = 1'b1;
    repeat (10) begin
      tick();
      chk("t4_busy_no_strobe", 32'(new_data_tx), 32'd0);
      chk("t4_busy_grant_held", 32'(grant_valid), 32'd1);
      chk("t4_busy_grant_id", 32'(grant_id), 32'd0);
    end
    busy = 1'b0;
    tick();
    chk("t4_busy_strobe", 32'(new_data_tx), 32'd1);
    chk("t4_busy_data", 32'(data_tx), 32'h52);
    chk("t4_busy_ack", 32'(req_ack), 32'b0001);

    // Same test with block instead of busy.
    idle(3);
    clear_reqs();
    b = log_n;
    put(3, 8'h61, 1'b0);
    put(3, 8'h62, 1'b1);
    present(3);
    wait_log(b + 1, 20);
    block = 1'b1;
    repeat (10) begin
      tick();
      chk("t4_block_no_strobe", 32'(new_data_tx), 32'd0);
      chk("t4_block_grant_held", 32'(grant_valid), 32'd1);
      chk("t4_block_grant_id", 32'(grant_id), 32'd3);
    end
    block = 1'b0;
    tick();
    chk("t4_block_strobe", 32'(new_data_tx), 32'd1);
    chk("t4_block_data", 32'(data_tx), 32'h62);
    chk("t4_block_ack", 32'(req_ack), 32'b1000);

    // MAX_BURST=4: requester 1 streams 6 bytes with no last flag, while requester 2 waits.
    idle(3);
    clear_reqs();
    b = log_n;
    for (int k = 0; k < 6; k++) put(1, 8'(8'h81 + k), 1'b0);
    put(2, 8'h90, 1'b1);
    present(1);
    tick();
    present(2);
    wait_log(b + 4, 40);
    chk("t5_forced_release", 32'(grant_valid), 32'd0);
    wait_log(b + 7, 60);
    for (int k = 0; k < 4; k++) exp_log("t5_first", b + k, 1, 8'(8'h81 + k));
    exp_log("t5_other", b + 4, 2, 8'h90);
    exp_log("t5_rest0", b + 5, 1, 8'h85);
    exp_log("t5_rest1", b + 6, 1, 8'h86);
    idle(6);
    chk("t5_no_extra", 32'(log_n), 32'(b + 7));
    chk("t5_idle_grant", 32'(grant_valid), 32'd0);

    // req_last on the same byte that reaches MAX_BURST.
    clear_reqs();
    b = log_n;
    g0 = g_n;
    put(0, 8'h71, 1'b0);
    put(0, 8'h72, 1'b0);
    put(0, 8'h73, 1'b0);
    put(0, 8'h74, 1'b1);
    present(0);
    wait_log(b + 4, 30);
    chk("t6_release", 32'(grant_valid), 32'd0);
    exp_log("t6_last", b + 3, 0, 8'h74);
    idle(5);
    chk("t6_single_grant", 32'(g_n - g0), 32'd1);
    chk("t6_no_extra", 32'(log_n), 32'(b + 4));

    // Abandon: requester 3 drops req while waiting on busy.
    clear_reqs();
    busy = 1'b1;
    b = log_n;
    put(3, 8'hC3, 1'b1);
    present(3);
    tick();
    chk("t7_grant_valid", 32'(grant_valid), 32'd1);
    chk("t7_grant_id", 32'(grant_id), 32'd3);
    req[3] = 1'b0;
    tick();
    chk("t7_released", 32'(grant_valid), 32'd0);
    chk("t7_no_ack", 32'(req_ack), 32'd0);
    busy = 1'b0;
    idle(5);
    chk("t7_no_byte", 32'(log_n), 32'(b));

    // Reset mid-burst, with the rr pointer left at 3.
    clear_reqs();
    b = log_n;
    put(2, 8'hD0, 1'b1);
    present(2);
    wait_log(b + 1, 20);
    idle(3);
    clear_reqs();
    b = log_n;
    put(2, 8'hE1, 1'b0);
    put(2, 8'hE2, 1'b0);
    put(2, 8'hE3, 1'b1);
    present(2);
    wait_log(b + 1, 20);
    chk("t8_mid_strobe", 32'(new_data_tx), 32'd1);
    rst = 1'b1;
    #1;
    chk_zero_outputs("t8_async_rst");
    tick();
    clear_reqs();
    rst = 1'b0;
    b = log_n;
    for (int i = 0; i < 4; i++) begin
      put(i, 8'(8'hF0 + i), 1'b1);
      present(i);
    end
    tick();
    chk("t8_restart_valid", 32'(grant_valid), 32'd1);
    chk("t8_restart_id", 32'(grant_id), 32'd0);
    wait_log(b + 4, 40);
    for (int i = 0; i < 4; i++) exp_log("t8_order", b + i, i, 8'(8'hF0 + i));
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
